router_input_buffer: RTL and testbench

Per-port ingress stage of the AXI-NoC router: buffers incoming AXIS flits in a small FIFO, decodes the routing header at the FIFO head, and holds `target_x_o`/`target_y_o` stable for the whole packet. It sits directly upstream of the router's per-input routing/demux stage, which consumes `out_mosi_o` together with the latched target coordinates. It also exports occupancy and drop events for the PMUs.

---
 rtl/router_input_buffer_pkg.sv | 35 +++
 rtl/router_input_buffer_if.sv | 12 +
 rtl/axis_sync_fifo.sv | 62 ++++++
 rtl/router_input_buffer.sv | 107 ++++++++++
 tb/tb_router_input_buffer.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/router_input_buffer_pkg.sv
// Shared AXIS flit types and router ingress state encoding.
// Imported by the ingress buffer, its FIFO, the handshake interface and the PMU taps.
package router_input_buffer_pkg;

   localparam int AXIS_DATA_WIDTH = 40;
   localparam int ID_WIDTH        = 4;

   localparam logic [ID_WIDTH-1:0] ROUTING_HEADER = 4'hA;

   typedef struct packed {
      logic [AXIS_DATA_WIDTH-1:0] TDATA;
      logic [ID_WIDTH-1:0]        TID;
      logic                       TLAST;
   } axis_data_t;

   typedef struct packed {
      logic       TVALID;
      axis_data_t data;
   } axis_mosi_t;

   typedef struct packed {
      logic TREADY;
   } axis_miso_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LATCH = 2'd1,
      FWD   = 2'd2
   } router_in_state_t;

   function automatic logic is_header(input logic [ID_WIDTH-1:0] tid);
      return tid == ROUTING_HEADER;
   endfunction

endpackage

// File: rtl/router_input_buffer_if.sv
// One AXIS link: forward flit bundle plus reverse TREADY.
// master drives flits and samples TREADY; slave does the opposite.
interface router_input_buffer_if;
   import router_input_buffer_pkg::*;

   axis_mosi_t mosi;
   axis_miso_t miso;

   modport master (output mosi, input  miso);
   modport slave  (input  mosi, output miso);

endinterface

// File: rtl/axis_sync_fifo.sv
// Flit FIFO, head visible one cycle after a push into an empty FIFO.
// Push is ignored while full (no same-cycle bypass); pop is ignored while empty.
module axis_sync_fifo
   import router_input_buffer_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic                     push_i,
   input  axis_data_t               push_dat_i,
   input  logic                     pop_i,
   output axis_data_t               head_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   axis_data_t    mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          push_ok, pop_ok;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;
   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
      else if (!push_ok && pop_ok) count_d = count_q - CW'(1);
   end

   // Storage is deliberately left out of reset; only pointers define validity.
   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/router_input_buffer.sv
// Router ingress: FIFO + header decode, targets held per packet; header out 2 cycles after accept.
// Input TREADY = FIFO not full, never combinational on out_if TREADY; output holds until handshake.
module router_input_buffer
   import router_input_buffer_pkg::*;
#(
   parameter int FIFO_DEPTH    = 4,
   parameter int MAX_ROUTERS_X = 4,
   parameter int MAX_ROUTERS_Y = 4
) (
   input  logic                               clk_i,
   input  logic                               rst_n_i,
   router_input_buffer_if.slave               in_if,
   router_input_buffer_if.master              out_if,
   output logic [$clog2(MAX_ROUTERS_X)-1:0]   target_x_o,
   output logic [$clog2(MAX_ROUTERS_Y)-1:0]   target_y_o,
   output logic [$clog2(FIFO_DEPTH):0]        count_o,
   output logic                               drop_o
);

   localparam int XW = $clog2(MAX_ROUTERS_X);
   localparam int YW = $clog2(MAX_ROUTERS_Y);

   router_in_state_t state_q, state_d;
   logic [XW-1:0]    target_x_q, target_x_d;
   logic [YW-1:0]    target_y_q, target_y_d;
   axis_data_t       head;
   logic             fifo_full, fifo_empty;
   logic             pop, out_vld;

   axis_sync_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .push_i     (in_if.mosi.TVALID),
      .push_dat_i (in_if.mosi.data),
      .pop_i      (pop),
      .head_o     (head),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .count_o    (count_o)
   );

   assign in_if.miso.TREADY = !fifo_full;
   assign target_x_o        = target_x_q;
   assign target_y_o        = target_y_q;

   always_comb begin
      state_d    = state_q;
      target_x_d = target_x_q;
      target_y_d = target_y_q;
      pop        = 1'b0;
      drop_o     = 1'b0;
      out_vld    = 1'b0;
      unique case (state_q)
         IDLE: begin
            // The header stays in the FIFO; it is presented from LATCH.
            if (!fifo_empty) begin
               if (is_header(head.TID)) begin
                  target_x_d = head.TDATA[XW-1:0];
                  target_y_d = head.TDATA[XW+YW-1:XW];
                  state_d    = LATCH;
               end else begin
                  pop    = 1'b1;
                  drop_o = 1'b1;
               end
            end
         end
         LATCH: begin
            out_vld = 1'b1;
            if (out_if.miso.TREADY) begin
               pop     = 1'b1;
               state_d = head.TLAST ? IDLE : FWD;
            end
         end
         FWD: begin
            out_vld = !fifo_empty;
            if (out_vld && out_if.miso.TREADY) begin
               pop = 1'b1;
               if (head.TLAST) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      out_if.mosi = '0;
      if (out_vld) begin
         out_if.mosi.TVALID = 1'b1;
         out_if.mosi.data   = head;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q    <= IDLE;
         target_x_q <= '0;
         target_y_q <= '0;
      end else begin
         state_q    <= state_d;
         target_x_q <= target_x_d;
         target_y_q <= target_y_d;
      end
   end

endmodule

// File: tb/tb_router_input_buffer.sv
// Bench for router_input_buffer: directed timing checks plus random packets vs a packet-level model.
module tb_router_input_buffer;
   import router_input_buffer_pkg::*;

   typedef struct {
      bit         drop;
      axis_data_t d;
      logic [1:0] tx;
      logic [1:0] ty;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   router_input_buffer_if in_if ();
   router_input_buffer_if out_if ();

   logic [1:0] target_x, target_y;
   logic [2:0] count;
   logic       drop;
   logic       dir_rdy = 1'b0;
   logic       rnd_rdy = 1'b0;
   logic       rand_en = 1'b0;

   assign out_if.miso.TREADY = rand_en ? rnd_rdy : dir_rdy;

   router_input_buffer #(
      .FIFO_DEPTH    (4),
      .MAX_ROUTERS_X (4),
      .MAX_ROUTERS_Y (4)
   ) dut (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .in_if      (in_if),
      .out_if     (out_if),
      .target_x_o (target_x),
      .target_y_o (target_y),
      .count_o    (count),
      .drop_o     (drop)
   );

   int   n_chk  = 0;
   int   n_pass = 0;
   exp_t exp_q[$];
   bit   in_pkt = 0;
   logic [1:0] cur_x = 2'd0;
   logic [1:0] cur_y = 2'd0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // Packet framing model: a header opens a packet, TLAST closes it, anything outside a packet is dropped.
   function automatic void model_accept(input axis_data_t d);
      exp_t e;
      e.d = d;
      if (!in_pkt && d.TID != ROUTING_HEADER) begin
         e.drop = 1'b1;
         e.tx   = 2'd0;
         e.ty   = 2'd0;
      end else begin
         if (!in_pkt) begin
            cur_x = d.TDATA[1:0];
            cur_y = d.TDATA[3:2];
         end
         e.drop = 1'b0;
         e.tx   = cur_x;
         e.ty   = cur_y;
         in_pkt = !d.TLAST;
      end
      exp_q.push_back(e);
   endfunction

   task automatic send_flit(input logic [3:0] tid, input logic [39:0] tdata, input logic tlast);
      axis_data_t d;
      bit hs = 1'b0;
      int n  = 0;
      d.TID   = tid;
      d.TDATA = tdata;
      d.TLAST = tlast;
      in_if.mosi.TVALID = 1'b1;
      in_if.mosi.data   = d;
      while (!hs && n < 200) begin
         @(negedge clk);
         hs = in_if.miso.TREADY;
         @(posedge clk);
         n++;
      end
      #1 in_if.mosi.TVALID = 1'b0;
      if (hs) model_accept(d);
      else check("send_timeout", 64'd0, 64'd1);
   endtask

   function automatic logic [39:0] rnd40();
      return 40'({$urandom(), $urandom()});
   endfunction

   function automatic logic [3:0] stray_tid();
      return ROUTING_HEADER ^ 4'($urandom_range(1, 15));
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         #1 rnd_rdy = ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor: pops the scoreboard on every output handshake or drop pulse.
   initial begin : monitor
      exp_t       e;
      bit         prev_stall = 1'b0;
      axis_data_t prev_dat   = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_stall = 1'b0;
         end else begin
            if (out_if.mosi.TVALID) begin
               if (prev_stall) check("axis_hold", out_if.mosi.data, prev_dat);
               if (out_if.miso.TREADY) begin
                  if (exp_q.size() == 0) begin
                     check("unexpected_flit", 64'd1, 64'd0);
                  end else begin
                     e = exp_q.pop_front();
                     check("flit_not_drop", e.drop, 1'b0);
                     check("flit_data", out_if.mosi.data, e.d);
                     check("flit_target_x", target_x, e.tx);
                     check("flit_target_y", target_y, e.ty);
                  end
               end
               prev_stall = !out_if.miso.TREADY;
               prev_dat   = out_if.mosi.data;
            end else begin
               if (prev_stall) check("valid_withdrawn", 64'd0, 64'd1);
               prev_stall = 1'b0;
               check("idle_out_zero", out_if.mosi, '0);
            end
            if (drop) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_drop", 64'd1, 64'd0);
               end else begin
                  e = exp_q.pop_front();
                  check("drop_expected", e.drop, 1'b1);
               end
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : stim
      logic [1:0] sx, sy;
      int         wait_n;
      in_if.mosi = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      @(negedge clk);
      check("rst_tready", in_if.miso.TREADY, 1'b1);
      check("rst_count", count, 3'd0);
      check("rst_tvalid", out_if.mosi.TVALID, 1'b0);
      check("rst_tx", target_x, 2'd0);
      check("rst_ty", target_y, 2'd0);
      check("rst_drop", drop, 1'b0);

      // Single-flit packet: X=1, Y=2.
      @(posedge clk); #1 dir_rdy = 1'b1;
      send_flit(ROUTING_HEADER, 40'h9, 1'b1);
      @(negedge clk);
      check("single_c1_count", count, 3'd1);
      check("single_c1_valid", out_if.mosi.TVALID, 1'b0);
      @(negedge clk);
      check("single_c2_valid", out_if.mosi.TVALID, 1'b1);
      check("single_c2_tx", target_x, 2'd1);
      check("single_c2_ty", target_y, 2'd2);
      @(negedge clk);
      check("single_c3_count", count, 3'd0);
      check("single_c3_valid", out_if.mosi.TVALID, 1'b0);

      // Back-pressure fill and release.
      @(posedge clk); #1 dir_rdy = 1'b0;
      send_flit(ROUTING_HEADER, rnd40(), 1'b0);
      for (int i = 0; i < 3; i++) send_flit(4'($urandom), rnd40(), i == 2);
      @(negedge clk);
      check("fill_tready", in_if.miso.TREADY, 1'b0);
      check("fill_count", count, 3'd4);
      @(posedge clk); #1 dir_rdy = 1'b1;
      @(negedge clk);
      check("release_tready_pop_cycle", in_if.miso.TREADY, 1'b0);
      check("release_valid", out_if.mosi.TVALID, 1'b1);
      @(negedge clk);
      check("release_tready_after", in_if.miso.TREADY, 1'b1);
      for (int i = 0; i < 3; i++) begin
         if (i > 0) @(negedge clk);
         check("release_count", count, 3'(3 - i));
         check("release_streaming", out_if.mosi.TVALID, 1'b1);
      end
      @(negedge clk);
      check("release_empty", count, 3'd0);

      // Simultaneous push/pop at count=2 across pointer wrap.
      @(posedge clk); #1;
      for (int i = 0; i < 10; i++) begin
         send_flit((i == 0) ? ROUTING_HEADER : 4'($urandom), rnd40(), i == 9);
         if (i >= 1) check("steady_count", count, 3'd2);
      end
      repeat (4) @(posedge clk);
      #1;

      // Stray body flit in IDLE.
      sx = target_x;
      sy = target_y;
      send_flit(stray_tid(), rnd40(), 1'($urandom));
      @(negedge clk);
      check("stray_drop_hi", drop, 1'b1);
      check("stray_no_out", out_if.mosi.TVALID, 1'b0);
      @(negedge clk);
      check("stray_drop_lo", drop, 1'b0);
      check("stray_count", count, 3'd0);
      check("stray_tx_kept", target_x, sx);
      check("stray_ty_kept", target_y, sy);

      // Back-to-back packets with the one-cycle bubble.
      @(posedge clk); #1;
      send_flit(ROUTING_HEADER, 40'h3, 1'b0);
      send_flit(4'($urandom), rnd40(), 1'b0);
      send_flit(4'($urandom), rnd40(), 1'b1);
      send_flit(ROUTING_HEADER, 40'hC, 1'b1);
      @(negedge clk);
      check("b2b_last_valid", out_if.mosi.TVALID, 1'b1);
      check("b2b_last_tlast", out_if.mosi.data.TLAST, 1'b1);
      check("b2b_last_tx", target_x, 2'd3);
      check("b2b_last_ty", target_y, 2'd0);
      @(negedge clk);
      check("b2b_bubble_valid", out_if.mosi.TVALID, 1'b0);
      check("b2b_bubble_tx", target_x, 2'd3);
      check("b2b_bubble_ty", target_y, 2'd0);
      @(negedge clk);
      check("b2b_hdr2_valid", out_if.mosi.TVALID, 1'b1);
      check("b2b_hdr2_tx", target_x, 2'd0);
      check("b2b_hdr2_ty", target_y, 2'd3);

      // Reset mid-packet.
      @(posedge clk); #1 dir_rdy = 1'b0;
      send_flit(ROUTING_HEADER, rnd40(), 1'b0);
      send_flit(4'($urandom), rnd40(), 1'b0);
      rst_n = 1'b0;
      exp_q.delete();
      in_pkt = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      check("midrst_count", count, 3'd0);
      check("midrst_valid", out_if.mosi.TVALID, 1'b0);
      check("midrst_tx", target_x, 2'd0);
      check("midrst_ty", target_y, 2'd0);
      @(posedge clk); #1 dir_rdy = 1'b1;
      send_flit(ROUTING_HEADER, 40'h6, 1'b1);
      repeat (4) @(posedge clk);
      #1;

      // Random packets, strays and gaps under random back-pressure.
      rand_en = 1'b1;
      for (int p = 0; p < 40; p++) begin
         int len;
         int gap;
         if ($urandom_range(0, 4) == 0) begin
            send_flit(stray_tid(), rnd40(), 1'($urandom));
         end else begin
            len = $urandom_range(1, 5);
            send_flit(ROUTING_HEADER, rnd40(), len == 1);
            for (int b = 1; b < len; b++) send_flit(4'($urandom), rnd40(), b == len - 1);
         end
         gap = $urandom_range(0, 2);
         if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
         end
      end
      rand_en = 1'b0;
      dir_rdy = 1'b1;
      wait_n  = 0;
      while (exp_q.size() != 0 && wait_n < 200) begin
         @(posedge clk);
         wait_n++;
      end
      @(negedge clk);
      check("drain_scoreboard_empty", exp_q.size(), 0);
      check("drain_count", count, 3'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
